// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: D-stage decode inputs, hazard controls and ID/EX control outputs
interface pipelined_control_unit_if #(parameter int ALU_CTRL_W = 4);
  logic [6:0] OpD;
  logic [2:0] funct3D;
  logic [6:0] funct7D;
  logic ValidD;
  logic StallE;
  logic FlushE;
  logic [2:0] ImmSrcD;
  logic IllegalD;
  logic RegWriteE;
  logic MemWriteE;
  logic ALUSrcE;
  logic BranchE;
  logic JumpE;
  logic JalrE;
  logic [1:0] ResultSrcE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic MulDivE;
  logic [2:0] MulDivOpE;
  logic IllegalE;
  logic MdBusy;
  logic MdDone;
  modport master (
    output OpD, funct3D, funct7D, ValidD, StallE, FlushE,
    input ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE,
    input ResultSrcE, ALUControlE, MulDivE, MulDivOpE, IllegalE, MdBusy, MdDone
  );
  modport slave (
    input OpD, funct3D, funct7D, ValidD, StallE, FlushE,
    output ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE,
    output ResultSrcE, ALUControlE, MulDivE, MulDivOpE, IllegalE, MdBusy, MdDone
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32IM decode with a registered ID/EX control stage and a mul/div hold sequencer
module pipelined_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter bit MEXT_EN = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input logic clk,
  input logic rst,
  pipelined_control_unit_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
    logic jalr;
    logic [1:0] result_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic mul_div;
    logic [2:0] mul_div_op;
    logic illegal;
  } ctrl_t;
  localparam logic [3:0] MUL_LAT = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t ctrl_q, ctrl_d, dec;
  logic [2:0] imm_src;
  logic bad;
  logic busy;
  logic capture;
  logic [3:0] lat_d;
  logic [3:0] lat_e;
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    return f3 == 3'd0 ? {3'b000, alt} : f3 == 3'd1 ? 4'd7 : f3 == 3'd2 ? 4'd5 :
           f3 == 3'd3 ? 4'd6 : f3 == 3'd4 ? 4'd4 : f3 == 3'd5 ? {3'b100, alt} :
           f3 == 3'd6 ? 4'd3 : 4'd2;
  endfunction
  always_comb begin
    dec = '0;
    imm_src = 3'b000;
    bad = 1'b0;
    case (bus.OpD)
      7'b0110011: begin
        dec.reg_write = 1'b1;
        if (MEXT_EN && bus.funct7D == 7'b0000001) begin
          dec.mul_div = 1'b1;
          dec.mul_div_op = bus.funct3D;
        end else if (bus.funct7D == 7'b0000000 || bus.funct7D == 7'b0100000)
          dec.alu_ctrl = ALU_CTRL_W'(alu_op(bus.funct3D, bus.funct7D[5]));
        else
          bad = 1'b1;
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(alu_op(bus.funct3D, bus.funct7D[5] && bus.funct3D == 3'd5));
      end
      7'b0000011: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.result_src = 2'b01;
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.alu_src = 1'b1;
        imm_src = 3'b001;
      end
      7'b1100011: begin
        dec.branch = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(1);
        imm_src = 3'b010;
      end
      7'b1101111: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.result_src = 2'b10;
        imm_src = 3'b011;
      end
      7'b1100111: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.jalr = 1'b1;
        dec.alu_src = 1'b1;
        dec.result_src = 2'b10;
      end
      7'b0110111: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(10);
        imm_src = 3'b100;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        imm_src = 3'b100;
      end
      default: bad = 1'b1;
    endcase
    if (bad)
      dec = '0;
    dec.illegal = bus.ValidD & bad;
  end
  // cnt_q counts the busy cycles still to go, including the current one
  assign busy = state_q == BUSY;
  assign capture = !busy && !bus.StallE && !bus.FlushE && bus.ValidD;
  assign lat_d = bus.funct3D[2] ? DIV_LAT : MUL_LAT;
  assign lat_e = ctrl_q.mul_div_op[2] ? DIV_LAT : MUL_LAT;
  always_comb begin
    ctrl_d = (busy || bus.StallE) ? ctrl_q : (bus.FlushE || !bus.ValidD) ? ctrl_t'('0) : dec;
    state_d = busy ? (cnt_q == 4'd1 ? IDLE : BUSY) :
              (capture && dec.mul_div && lat_d != 4'd0) ? BUSY : IDLE;
    cnt_d = busy ? cnt_q - 4'd1 : lat_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
    end
  end
  assign bus.ImmSrcD = imm_src;
  assign bus.IllegalD = dec.illegal;
  assign bus.RegWriteE = ctrl_q.reg_write;
  assign bus.MemWriteE = ctrl_q.mem_write;
  assign bus.ALUSrcE = ctrl_q.alu_src;
  assign bus.BranchE = ctrl_q.branch;
  assign bus.JumpE = ctrl_q.jump;
  assign bus.JalrE = ctrl_q.jalr;
  assign bus.ResultSrcE = ctrl_q.result_src;
  assign bus.ALUControlE = ctrl_q.alu_ctrl;
  assign bus.MulDivE = ctrl_q.mul_div;
  assign bus.MulDivOpE = ctrl_q.mul_div_op;
  assign bus.IllegalE = ctrl_q.illegal;
  assign bus.MdBusy = busy;
  assign bus.MdDone = busy ? cnt_q == 4'd1 : ctrl_q.mul_div && lat_e == 4'd0;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: random and directed decode/stall/mul-div traffic on an M and a non-M instance,
// scored against a residence-count reference model
module tb_pipelined_control_unit;
  typedef struct packed {
    logic rw;
    logic mw;
    logic as;
    logic br;
    logic jp;
    logic jr;
    logic [1:0] rs;
    logic [3:0] alu;
    logic md;
    logic [2:0] mop;
    logic il;
  } ectl_t;
  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
  localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [22:0] q_m [$];
  logic [22:0] q_b [$];
  ectl_t e_m [2];
  int n_m [2];
  int age_m [2];
  logic [22:0] act_m;
  logic [22:0] act_b;
  always #5 clk = ~clk;
  pipelined_control_unit_if #(.ALU_CTRL_W(4)) ifm ();
  pipelined_control_unit_if #(.ALU_CTRL_W(4)) ifb ();
  pipelined_control_unit #(.ALU_CTRL_W(4), .MEXT_EN(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(8))
    dut_m (.clk(clk), .rst(rst), .bus(ifm));
  pipelined_control_unit #(.ALU_CTRL_W(4), .MEXT_EN(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(8))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  assign act_m = {ifm.ImmSrcD, ifm.IllegalD, ifm.RegWriteE, ifm.MemWriteE, ifm.ALUSrcE, ifm.BranchE,
                  ifm.JumpE, ifm.JalrE, ifm.ResultSrcE, ifm.ALUControlE, ifm.MulDivE, ifm.MulDivOpE,
                  ifm.IllegalE, ifm.MdBusy, ifm.MdDone};
  assign act_b = {ifb.ImmSrcD, ifb.IllegalD, ifb.RegWriteE, ifb.MemWriteE, ifb.ALUSrcE, ifb.BranchE,
                  ifb.JumpE, ifb.JalrE, ifb.ResultSrcE, ifb.ALUControlE, ifb.MulDivE, ifb.MulDivOpE,
                  ifb.IllegalE, ifb.MdBusy, ifb.MdDone};
  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    return op == 7'h23 ? 3'd1 : op == 7'h63 ? 3'd2 : op == 7'h6F ? 3'd3 :
           (op == 7'h37 || op == 7'h17) ? 3'd4 : 3'd0;
  endfunction
  function automatic ectl_t ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    input bit mext, input bit v);
    ectl_t c;
    bit legal;
    c = '0;
    legal = 1;
    case (op)
      7'h33: begin
        c.rw = 1;
        if (mext && f7 == 7'h01) begin
          c.md = 1;
          c.mop = f3;
        end else if (f7 == 7'h00 || f7 == 7'h20)
          c.alu = ALU_TAB[f3] + ((f7[5] && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
        else
          legal = 0;
      end
      7'h13: begin
        c.rw = 1;
        c.as = 1;
        c.alu = ALU_TAB[f3] + ((f7[5] && f3 == 3'd5) ? 4'd1 : 4'd0);
      end
      7'h03: begin c.rw = 1; c.as = 1; c.rs = 2'd1; end
      7'h23: begin c.mw = 1; c.as = 1; end
      7'h63: begin c.br = 1; c.alu = 4'd1; end
      7'h6F: begin c.rw = 1; c.jp = 1; c.rs = 2'd2; end
      7'h67: begin c.rw = 1; c.jp = 1; c.jr = 1; c.as = 1; c.rs = 2'd2; end
      7'h37: begin c.rw = 1; c.as = 1; c.alu = 4'd10; end
      7'h17: begin c.rw = 1; c.as = 1; end
      default: legal = 0;
    endcase
    if (!legal)
      c = '0;
    c.il = v && !legal;
    return c;
  endfunction
  task automatic check(input int d, input logic [22:0] exp, input logic [22:0] got);
    checks += 2;
    if (got[22:19] !== exp[22:19]) begin
      errors++;
      $display("FAIL dstage dut%0d t=%0t imm/illegal got %h expected %h", d, $time, got[22:19], exp[22:19]);
    end
    if (got[18:0] !== exp[18:0]) begin
      errors++;
      $display("FAIL estage dut%0d t=%0t ctrl/busy/done got %h expected %h", d, $time, got[18:0], exp[18:0]);
    end
  endtask
  always @(negedge clk) begin
    if (q_m.size() != 0) check(0, q_m.pop_front(), act_m);
    if (q_b.size() != 0) check(1, q_b.pop_front(), act_b);
  end
  task automatic step(input bit r, input bit v, input bit st, input bit fl,
                      input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [22:0] ex [2];
    @(negedge clk);
    #1;
    rst = r;
    ifm.ValidD = v; ifm.StallE = st; ifm.FlushE = fl; ifm.OpD = op; ifm.funct3D = f3; ifm.funct7D = f7;
    ifb.ValidD = v; ifb.StallE = st; ifb.FlushE = fl; ifb.OpD = op; ifb.funct3D = f3; ifb.funct7D = f7;
    for (int d = 0; d < 2; d++) begin
      ectl_t dec;
      bit hold;
      bit bz;
      bit dn;
      dec = ref_dec(op, f3, f7, d == 0, v);
      hold = (n_m[d] > 1 && age_m[d] < n_m[d]) || st;
      if (r) begin
        e_m[d] = '0; n_m[d] = 0; age_m[d] = 0;
      end else if (hold)
        age_m[d]++;
      else if (fl || !v) begin
        e_m[d] = '0; n_m[d] = 0; age_m[d] = 0;
      end else begin
        e_m[d] = dec;
        n_m[d] = dec.md ? (f3[2] ? 8 : 2) : 0;
        age_m[d] = 1;
      end
      bz = n_m[d] > 1 && age_m[d] < n_m[d];
      dn = n_m[d] > 1 ? age_m[d] == n_m[d] - 1 : n_m[d] == 1;
      ex[d] = {ref_imm(op), dec.il, e_m[d], bz, dn};
    end
    @(posedge clk);
    q_m.push_back(ex[0]);
    q_b.push_back(ex[1]);
  endtask
  initial begin
    logic [6:0] op;
    logic [6:0] f7;
    ifm.ValidD = 1'b1; ifm.StallE = 1'b0; ifm.FlushE = 1'b0; ifm.OpD = 7'h33; ifm.funct3D = 3'd0; ifm.funct7D = 7'h00;
    ifb.ValidD = 1'b1; ifb.StallE = 1'b0; ifb.FlushE = 1'b0; ifb.OpD = 7'h33; ifb.funct3D = 3'd0; ifb.funct7D = 7'h00;
    step(1, 1, 0, 0, 7'h33, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h33, 3'd0, 7'h20);
    step(0, 1, 0, 0, 7'h13, 3'd5, 7'h20);
    step(0, 1, 0, 0, 7'h13, 3'd0, 7'h20);
    step(0, 1, 0, 0, 7'h03, 3'd2, 7'h00);
    step(0, 1, 0, 0, 7'h23, 3'd2, 7'h00);
    step(0, 1, 0, 0, 7'h63, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h6F, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h67, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h37, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h17, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h7F, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h33, 3'd7, 7'h10);
    step(0, 1, 0, 0, 7'h33, 3'd0, 7'h01);
    repeat (2) step(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h33, 3'd4, 7'h01);
    repeat (3) step(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
    step(0, 1, 0, 1, 7'h33, 3'd0, 7'h00);
    repeat (4) step(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
    repeat (18) step(0, 1, 0, 0, 7'h33, 3'd5, 7'h01);
    step(0, 1, 1, 1, 7'h33, 3'd0, 7'h00);
    step(0, 1, 0, 1, 7'h33, 3'd0, 7'h00);
    step(0, 0, 0, 0, 7'h33, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h33, 3'd6, 7'h01);
    repeat (3) step(0, 1, 0, 0, 7'h33, 3'd0, 7'h00);
    step(1, 1, 0, 0, 7'h33, 3'd0, 7'h00);
    step(0, 1, 0, 0, 7'h33, 3'd1, 7'h00);
    for (int i = 0; i < 500; i++) begin
      op = $urandom_range(0, 9) == 9 ? 7'($urandom) : OPS[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, op, 3'($urandom), f7);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q_m.size() + q_b.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q_m.size() + q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
